// File: rtl/ann_ic_pkg.sv
// Shared definitions for the ANN-layer interconnect controllers:
// Benes network geometry, route-table entry layout and sequencer state encoding.
package ann_ic_pkg;

    localparam int BENES_PORTS  = 8;
    localparam int BENES_CTRL_W = 20;
    localparam int BENES_LAT    = 2;
    localparam logic [BENES_PORTS-1:0] PORT_DIS_N = 8'hFF;

    typedef struct packed {
        logic [BENES_CTRL_W-1:0] ctrl;
        logic [BENES_PORTS-1:0]  port_en_n;
        logic [7:0]              beats;
    } route_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    localparam route_entry_t ROUTE_RESET = '{ctrl: '0, port_en_n: PORT_DIS_N, beats: 8'd1};

    // A programmed beat count of zero still routes one beat.
    function automatic logic [7:0] beats_to_cnt(input logic [7:0] beats);
        return (beats == 8'd0) ? 8'd0 : beats - 8'd1;
    endfunction

endpackage

// File: rtl/benes_route_sequencer_if.sv
// Configuration, upstream handshake and network-drive signals of the route sequencer.
interface benes_route_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic                                 cfg_wr_en;
    logic [ADDR_W-1:0]                    cfg_wr_addr;
    logic [ann_ic_pkg::BENES_CTRL_W-1:0]  cfg_wr_ctrl;
    logic [ann_ic_pkg::BENES_PORTS-1:0]   cfg_wr_port_en_n;
    logic [7:0]                           cfg_wr_beats;
    logic [ADDR_W:0]                      num_entries;
    logic                                 start;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [ann_ic_pkg::BENES_CTRL_W-1:0]  benes_control;
    logic [ann_ic_pkg::BENES_PORTS-1:0]   benes_port_en_n;
    logic                                 out_valid;
    logic [ADDR_W-1:0]                    out_entry;
    logic                                 busy;
    logic                                 done;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_ctrl, cfg_wr_port_en_n, cfg_wr_beats,
        output num_entries, start, in_valid,
        input  in_ready, benes_control, benes_port_en_n, out_valid, out_entry, busy, done
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_ctrl, cfg_wr_port_en_n, cfg_wr_beats,
        input  num_entries, start, in_valid,
        output in_ready, benes_control, benes_port_en_n, out_valid, out_entry, busy, done
    );
endinterface

// File: rtl/route_valid_delay.sv
// LAT-deep valid+tag shift register matching a fixed-latency datapath.
// pend_o flags valid beats still in flight ahead of the output stage.
module route_valid_delay #(
    parameter int LAT   = 2,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             pend_o
);
    logic [LAT-1:0]   vld_q;
    logic [TAG_W-1:0] tag_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            tag_q[0] <= in_tag_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend_o = pend_o | vld_q[i];
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_tag_o   = tag_q[LAT-1];

endmodule

// File: rtl/benes_route_sequencer.sv
// Walks the route table one upstream beat at a time, drives the Benes network
// configuration and tags the network's delayed output with its entry index.
module benes_route_sequencer
    import ann_ic_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int LAT    = BENES_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    benes_route_sequencer_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    seq_state_t        state_q, state_d;
    route_entry_t      table_q [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d, last_q, last_d, ptr_nxt;
    logic [7:0]        cnt_q, cnt_d;
    logic              zdone_q, zdone_d;
    logic              wr_ok, fire, final_out, launch;
    logic [ADDR_W:0]   n_clamp;
    logic [7:0]        first_beats;
    logic              dl_valid, dl_pend;
    logic [ADDR_W-1:0] dl_tag;

    assign ptr_nxt   = ptr_q + ADDR_W'(1);
    assign wr_ok     = bus.cfg_wr_en && (state_q == ST_IDLE);
    assign fire      = bus.in_valid && (state_q == ST_RUN);
    assign final_out = (state_q == ST_DRAIN) && dl_valid && !dl_pend;
    // A new run may launch from IDLE or in the very cycle the previous one completes.
    assign launch    = bus.start && ((state_q == ST_IDLE) || final_out);
    assign n_clamp   = (bus.num_entries > DEPTH_N) ? DEPTH_N : bus.num_entries;
    // Entry 0 may be rewritten in the launch cycle; forward that beat count.
    assign first_beats = (wr_ok && (bus.cfg_wr_addr == '0)) ? bus.cfg_wr_beats : table_q[0].beats;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= ROUTE_RESET;
        end else if (wr_ok) begin
            table_q[bus.cfg_wr_addr] <= '{ctrl:      bus.cfg_wr_ctrl,
                                          port_en_n: bus.cfg_wr_port_en_n,
                                          beats:     bus.cfg_wr_beats};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        zdone_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (fire) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (ptr_q != last_q) begin
                        ptr_d = ptr_nxt;
                        cnt_d = beats_to_cnt(table_q[ptr_nxt].beats);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: if (final_out) state_d = ST_IDLE;
            default: ;
        endcase
        if (launch) begin
            if (bus.num_entries == '0) begin
                zdone_d = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RUN;
                ptr_d   = '0;
                last_d  = ADDR_W'(n_clamp - (ADDR_W+1)'(1));
                cnt_d   = beats_to_cnt(first_beats);
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_RUN);
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = zdone_q || final_out;
        bus.out_valid = dl_valid;
        bus.out_entry = dl_tag;
        if (state_q == ST_IDLE) begin
            bus.benes_control   = '0;
            bus.benes_port_en_n = PORT_DIS_N;
        end else begin
            bus.benes_control   = table_q[ptr_q].ctrl;
            bus.benes_port_en_n = table_q[ptr_q].port_en_n;
        end
    end

    route_valid_delay #(
        .LAT   (LAT),
        .TAG_W (ADDR_W)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (fire),
        .in_tag_i    (ptr_q),
        .out_valid_o (dl_valid),
        .out_tag_o   (dl_tag),
        .pend_o      (dl_pend)
    );

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Bench for benes_route_sequencer: beat-plan reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_benes_route_sequencer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int LAT    = 2;

    logic clk;
    logic rst;

    benes_route_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    benes_route_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the table, the remaining beat plan of the run (one entry
    // index per beat still to be accepted) and the beats in flight in the network.
    logic [19:0] t_ctrl  [DEPTH];
    logic [7:0]  t_en    [DEPTH];
    logic [7:0]  t_beats [DEPTH];
    int          plan[$];
    bit          m_busy, m_run, m_zdone;
    int          m_last;
    bit          pv [LAT];
    int          pt [LAT];
    bit          pf [LAT];

    int          fire_cyc[$];
    logic [19:0] fire_ctrl[$];
    int          ov_cyc[$];
    int          ov_ent[$];
    int          done_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            t_ctrl[i] = '0; t_en[i] = 8'hFF; t_beats[i] = 8'd1;
        end
        plan.delete();
        m_busy = 0; m_run = 0; m_zdone = 0; m_last = 0;
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 0; pt[i] = 0; pf[i] = 0;
        end
    endtask

    task automatic clear_logs();
        fire_cyc.delete(); fire_ctrl.delete(); ov_cyc.delete(); ov_ent.delete(); done_cyc.delete();
    endtask

    // Checks this cycle's outputs against the model, then advances the model across the edge.
    task automatic cycle();
        logic [19:0] e_ctrl;
        logic [7:0]  e_en;
        bit          e_done, fire, can_start;
        int          n, reps;
        #1;
        e_done = m_zdone || (pv[LAT-1] && pf[LAT-1]);
        if (m_run) begin
            e_ctrl = t_ctrl[plan[0]]; e_en = t_en[plan[0]];
        end else if (m_busy) begin
            e_ctrl = t_ctrl[m_last]; e_en = t_en[m_last];
        end else begin
            e_ctrl = '0; e_en = 8'hFF;
        end
        chk("busy",            32'(bus.busy),            32'(m_busy));
        chk("in_ready",        32'(bus.in_ready),        32'(m_run));
        chk("benes_control",   32'(bus.benes_control),   32'(e_ctrl));
        chk("benes_port_en_n", 32'(bus.benes_port_en_n), 32'(e_en));
        chk("out_valid",       32'(bus.out_valid),       32'(pv[LAT-1]));
        chk("done",            32'(bus.done),            32'(e_done));
        if (pv[LAT-1]) chk("out_entry", 32'(bus.out_entry), 32'(pt[LAT-1]));

        if (bus.in_ready && bus.in_valid) begin
            fire_cyc.push_back(cyc); fire_ctrl.push_back(bus.benes_control);
        end
        if (bus.out_valid) begin
            ov_cyc.push_back(cyc); ov_ent.push_back(int'(bus.out_entry));
        end
        if (bus.done) done_cyc.push_back(cyc);

        fire = m_run && bus.in_valid;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1]; pt[i] = pt[i-1]; pf[i] = pf[i-1];
        end
        pv[0] = fire;
        pt[0] = fire ? plan[0] : 0;
        pf[0] = fire && (plan.size() == 1);
        m_zdone = 0;
        if (fire) begin
            void'(plan.pop_front());
            if (plan.size() == 0) m_run = 0;
        end
        can_start = !m_busy || e_done;
        if (!m_busy && bus.cfg_wr_en) begin
            t_ctrl[bus.cfg_wr_addr]  = bus.cfg_wr_ctrl;
            t_en[bus.cfg_wr_addr]    = bus.cfg_wr_port_en_n;
            t_beats[bus.cfg_wr_addr] = bus.cfg_wr_beats;
        end
        if (e_done) m_busy = 0;
        if (can_start && bus.start) begin
            if (bus.num_entries == 0) begin
                m_zdone = 1;
            end else begin
                n = (int'(bus.num_entries) > DEPTH) ? DEPTH : int'(bus.num_entries);
                plan.delete();
                for (int e = 0; e < n; e++) begin
                    reps = (t_beats[e] == 0) ? 1 : int'(t_beats[e]);
                    for (int r = 0; r < reps; r++) plan.push_back(e);
                end
                m_busy = 1; m_run = 1; m_last = n - 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [19:0] ctrl, input logic [7:0] en, input logic [7:0] beats);
        bus.cfg_wr_en        = 1'b1;
        bus.cfg_wr_addr      = ADDR_W'(addr);
        bus.cfg_wr_ctrl      = ctrl;
        bus.cfg_wr_port_en_n = en;
        bus.cfg_wr_beats     = beats;
        cycle();
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic go(input int num);
        bus.start = 1'b1;
        bus.num_entries = (ADDR_W+1)'(num);
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int k = 0;
        while (done_cyc.size() == 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("done_within_bound", 32'(done_cyc.size()), 32'd1);
    endtask

    task automatic check_two_entry_logs(input string tag);
        chk({tag, "_fire_count"}, 32'(fire_ctrl.size()), 32'd3);
        chk({tag, "_ov_count"},   32'(ov_ent.size()),    32'd3);
        if (fire_ctrl.size() == 3) begin
            chk({tag, "_ctrl0"}, 32'(fire_ctrl[0]), 32'h00000);
            chk({tag, "_ctrl1"}, 32'(fire_ctrl[1]), 32'h00000);
            chk({tag, "_ctrl2"}, 32'(fire_ctrl[2]), 32'hFFFFF);
        end
        if (ov_ent.size() == 3 && fire_cyc.size() == 3 && done_cyc.size() == 1) begin
            chk({tag, "_ent0"}, 32'(ov_ent[0]), 32'd0);
            chk({tag, "_ent1"}, 32'(ov_ent[1]), 32'd0);
            chk({tag, "_ent2"}, 32'(ov_ent[2]), 32'd1);
            for (int i = 0; i < 3; i++)
                chk({tag, "_latency"}, 32'(ov_cyc[i] - fire_cyc[i]), 32'd2);
            chk({tag, "_done_with_last"}, 32'(done_cyc[0]), 32'(ov_cyc[2]));
        end
    endtask

    initial begin
        int s;
        int pat [5] = '{1, 0, 0, 1, 1};
        bit done_next;
        bus.cfg_wr_en = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_ctrl = '0;
        bus.cfg_wr_port_en_n = '0; bus.cfg_wr_beats = '0;
        bus.num_entries = '0; bus.start = 0; bus.in_valid = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy),            32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),        32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),       32'd0);
        chk("rst_done",      32'(bus.done),            32'd0);
        chk("rst_ctrl",      32'(bus.benes_control),   32'd0);
        chk("rst_en_n",      32'(bus.benes_port_en_n), 32'hFF);
        chk("rst_out_entry", 32'(bus.out_entry),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(); cycle();

        // Two-entry run, in_valid held high
        wr(0, 20'h00000, 8'h00, 8'd2);
        wr(1, 20'hFFFFF, 8'h0F, 8'd1);
        clear_logs();
        bus.in_valid = 1;
        go(2);
        run_until_done(20);
        bus.in_valid = 0;
        check_two_entry_logs("two_entry");
        cycle();

        // Stall pattern 1,0,0,1,1
        clear_logs();
        go(2);
        foreach (pat[i]) begin
            bus.in_valid = pat[i][0];
            cycle();
        end
        bus.in_valid = 0;
        run_until_done(10);
        check_two_entry_logs("stall");
        if (fire_cyc.size() == 3) begin
            chk("stall_gap0", 32'(fire_cyc[1] - fire_cyc[0]), 32'd3);
            chk("stall_gap1", 32'(fire_cyc[2] - fire_cyc[1]), 32'd1);
        end
        cycle();

        // Reset in the middle of a run with a beat in flight
        clear_logs();
        go(2);
        cycle();
        bus.in_valid = 1;
        cycle();
        bus.in_valid = 0;
        rst = 1'b1;
        #1;
        chk("midrst_busy",      32'(bus.busy),            32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),        32'd0);
        chk("midrst_en_n",      32'(bus.benes_port_en_n), 32'hFF);
        chk("midrst_out_valid", 32'(bus.out_valid),       32'd0);
        chk("midrst_ctrl",      32'(bus.benes_control),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle();
        chk("midrst_no_done", 32'(done_cyc.size()), 32'd0);

        // beats=0 on entry 0 and num_entries clamped from 9 to 8
        for (int e = 0; e < DEPTH; e++)
            wr(e, 20'($urandom), 8'($urandom), (e == 0) ? 8'd0 : 8'd1);
        clear_logs();
        bus.in_valid = 1;
        go(9);
        run_until_done(30);
        bus.in_valid = 0;
        chk("clamp_fire_count", 32'(fire_cyc.size()), 32'd8);
        chk("clamp_ov_count",   32'(ov_ent.size()),   32'd8);
        for (int i = 0; i < ov_ent.size() && i < 8; i++)
            chk("clamp_entry_seq", 32'(ov_ent[i]), 32'(i));
        cycle();

        // Zero-entry start
        clear_logs();
        s = cyc;
        go(0);
        cycle(); cycle();
        chk("zero_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() == 1) chk("zero_done_cycle", 32'(done_cyc[0]), 32'(s + 1));

        // Write protection while busy, then the same write from IDLE
        wr(0, 20'h00000, 8'h00, 8'd1);
        wr(1, 20'hFFFFF, 8'h0F, 8'd1);
        clear_logs();
        go(2);
        wr(1, 20'h12345, 8'h0F, 8'd1);
        bus.in_valid = 1;
        run_until_done(10);
        bus.in_valid = 0;
        cycle();
        clear_logs();
        bus.in_valid = 1;
        go(2);
        run_until_done(10);
        bus.in_valid = 0;
        chk("wp_fire_count", 32'(fire_ctrl.size()), 32'd2);
        if (fire_ctrl.size() == 2) chk("wp_busy_write_ignored", 32'(fire_ctrl[1]), 32'hFFFFF);
        wr(1, 20'h12345, 8'h0F, 8'd1);
        clear_logs();
        bus.in_valid = 1;
        go(2);
        run_until_done(10);
        bus.in_valid = 0;
        if (fire_ctrl.size() == 2) chk("wp_idle_write_lands", 32'(fire_ctrl[1]), 32'h12345);
        else chk("wp_idle_fire_count", 32'(fire_ctrl.size()), 32'd2);

        // Randomized traffic, including starts in the done cycle and writes while busy
        for (int it = 0; it < 2500; it++) begin
            done_next = pv[LAT-1] && pf[LAT-1];
            bus.cfg_wr_en        = ($urandom_range(0, 3) == 0);
            bus.cfg_wr_addr      = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.cfg_wr_ctrl      = 20'($urandom);
            bus.cfg_wr_port_en_n = 8'($urandom);
            bus.cfg_wr_beats     = 8'($urandom_range(0, 3));
            bus.start            = ($urandom_range(0, 7) == 0) || (done_next && $urandom_range(0, 1) == 1);
            bus.num_entries      = (ADDR_W+1)'($urandom_range(0, 9));
            bus.in_valid         = ($urandom_range(0, 9) < 6);
            cycle();
        end
        bus.cfg_wr_en = 0; bus.start = 0; bus.in_valid = 1;
        repeat (40) cycle();
        bus.in_valid = 0;
        repeat (5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
- Schedules routing configurations for the 8x8 Benes interconnect between ANN layers.
- Holds a small table of route entries. Each entry has a 20-bit switch control word, an 8-bit active-low port-enable mask and a beat count.
- On start, walks the table. For each accepted upstream beat it presents the matching control/port-enable to the network, then tracks the network's 2-cycle latency so outputs are tagged valid with their entry index.

Parameters:
- DEPTH, 8, number of route-table entries.
- ADDR_W, 3, width of entry index (clog2 DEPTH).
- LAT, 2, network latency in clock edges from input capture to registered output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_addr  in  ADDR_W  table entry written.
- cfg_wr_ctrl  in  20  switch control word (bit19 = stage0 switch0 ... bit0 = stage4 switch3).
- cfg_wr_port_en_n  in  8  active-low input port enables.
- cfg_wr_beats  in  8  beats routed with this entry (0 treated as 1).
- num_entries  in  ADDR_W+1  entries to run, 0..DEPTH; sampled on start.
- start  in  1  single-cycle run request.
- in_valid  in  1  upstream data beat valid.
- in_ready  out  1  sequencer accepts beat; data goes to network input this cycle.
- benes_control  out  20  drives network in_control_reg.
- benes_port_en_n  out  8  drives network port_en_n_reg.
- out_valid  out  1  network out_output holds a routed beat.
- out_entry  out  ADDR_W  entry index of that beat.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse, run complete.

Behaviour:
- Reset: state IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_entry=0, benes_control=0, benes_port_en_n=8'hFF.
- Reset also clears the table: ctrl=0, port_en_n=8'hFF, beats=1. It also clears the valid/entry delay line and all counters.
- Reset mid-run aborts immediately; no done pulse.
- Table: flop array, read combinationally at entry_ptr. Writes are ignored while busy=1. A write in the same cycle as an accepted start still lands, because busy is still 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - in_ready=0; control outputs hold their reset values.
  - start with num_entries>=1: latch n=min(num_entries,DEPTH), entry_ptr=0, beat_cnt=beats[0]-1 (0 counts as 1). Go to RUN; busy=1 from next cycle.
  - start with num_entries=0: done pulses next cycle; busy stays 0.
- RUN:
  - in_ready=1; benes_control/benes_port_en_n = table[entry_ptr], combinational from registered pointer.
  - fire = in_valid & in_ready.
  - On fire with beat_cnt>0: beat_cnt decrements.
  - On fire with beat_cnt=0 and entry_ptr<n-1: entry_ptr increments and beat_cnt reloads from the next entry. The next cycle already presents the new config.
  - On fire with beat_cnt=0 and entry_ptr=n-1: go to DRAIN.
  - in_valid low: hold everything, no timeout.
  - start while busy is ignored.
- DRAIN:
  - in_ready=0; control outputs hold the last entry's values.
  - Wait until the delay line is empty except the final beat.
  - done=1 in the same cycle as the final out_valid, then go to IDLE. busy drops the cycle after done.
- Delay line: LAT-stage shift register of {fire, entry_ptr}. out_valid/out_entry are the last stage.
  - A beat fired in cycle C yields out_valid in cycle C+LAT, the same cycle the network out_output shows it.
- Back-to-back: start accepted in the done cycle is legal. The pipeline from the previous run drains independently.

Decomposition:
- Shared package ann_ic_pkg:
  - constants BENES_PORTS=8, BENES_CTRL_W=20, BENES_LAT=2, PORT_DIS_N=8'hFF;
  - route-entry struct/typedef {ctrl[19:0], port_en_n[7:0], beats[7:0]};
  - FSM state encoding.
- One sub-module: route_valid_delay, a LAT-deep valid+tag shift register with async reset. It is reused by other interconnect controllers.

Test Plan:
- Reset defaults: assert rst mid-RUN -> same cycle busy=0, in_ready=0, benes_port_en_n=8'hFF, out_valid=0; no done pulse.
- Two-entry run:
  - Setup: entry0 {ctrl=20'h00000, en_n=8'h00, beats=2}, entry1 {ctrl=20'hFFFFF, en_n=8'h0F, beats=1}, num_entries=2, in_valid held 1.
  - Expected: control 00000 for 2 fires, then FFFFF for 1; out_entry sequence 0,0,1 starting 2 cycles after first fire; done coincides with 3rd out_valid.
- Stall: same table, in_valid toggles 1,0,0,1,1 -> entry advances only on fires; benes_control unchanged during stalls; 3 out_valid pulses, each 2 cycles after its fire.
- beats=0 and num_entries=9: entry0 beats=0, num_entries=9 -> entry0 routes exactly 1 beat; run covers 8 entries (clamped).
- Zero-entry start: num_entries=0, start -> done pulses next cycle, busy never asserts, in_ready stays 0.
- Write protection: cfg_wr_en to entry1 with ctrl=20'h12345 while busy -> ignored; table readback via a later run shows the old value; the same write in IDLE takes effect.
